br_resolve_unit: RTL and testbench

Branch execution end of the branch reservation-station issue interface. It accepts one issued branch or jump per cycle and reads its operands from the physical register file. It resolves direction and target, then broadcasts completion (BR_Phy/BR_Done wakeup), the mispredict flush pulse (Predict_Result), the redirect PC and the BTB update. It is a two-stage pipeline (E1 operand read, E2 resolve) and also keeps branch and mispredict statistics counters.

---
 rtl/br_resolve_unit.sv | 171 +++++++++++++++++
 tb/tb_br_resolve_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// Branch execution unit: E1 reads PRF operands, E2 resolves direction/target and
// registers completion, flush pulse, redirect PC, BTB update and statistics counters.
module br_resolve_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PHY_W = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exception_sig,
   input  logic             mret_sig,
   input  logic             in_branch,
   input  logic             in_jump,
   input  logic             in_jalr,
   input  logic             in_hit,
   input  logic             in_taken,
   input  logic [PHY_W-1:0] in_phy,
   input  logic [31:0]      in_inst_num,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [PHY_W-1:0] in_op1_phy,
   input  logic [PHY_W-1:0] in_op2_phy,
   output logic [PHY_W-1:0] prf_raddr1,
   output logic [PHY_W-1:0] prf_raddr2,
   input  logic [XLEN-1:0]  prf_rdata1,
   input  logic [XLEN-1:0]  prf_rdata2,
   output logic             br_done,
   output logic [PHY_W-1:0] br_phy,
   output logic [XLEN-1:0]  br_wdata,
   output logic [31:0]      br_inst_num,
   output logic             predict_result,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             btb_upd_valid,
   output logic [XLEN-1:0]  btb_upd_pc,
   output logic [XLEN-1:0]  btb_upd_target,
   output logic             btb_upd_taken,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   typedef struct packed {
      logic             v;
      logic             jump;
      logic             jalr;
      logic             hit;
      logic             taken;
      logic [PHY_W-1:0] phy;
      logic [31:0]      inst_num;
      logic [2:0]       funct3;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
      logic [PHY_W-1:0] op1;
      logic [PHY_W-1:0] op2;
   } e1_t;

   typedef struct packed {
      logic             pr;
      logic [XLEN-1:0]  redirect;
      logic             btb_v;
      logic [XLEN-1:0]  btb_pc;
      logic [XLEN-1:0]  btb_tgt;
      logic             btb_taken;
      logic             done;
      logic [PHY_W-1:0] phy;
      logic [XLEN-1:0]  wdata;
      logic [31:0]      inst_num;
   } e2_t;

   e1_t e1_q, e1_d;
   e2_t e2_q, e2_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic            cond_taken, legal, res_taken, mispredict, link;
   logic [XLEN-1:0] target, pc4, sum_reg;

   always_comb begin
      cond_taken = 1'b0;
      legal      = 1'b1;
      case (e1_q.funct3)
         3'b000:  cond_taken = (prf_rdata1 == prf_rdata2);
         3'b001:  cond_taken = (prf_rdata1 != prf_rdata2);
         3'b100:  cond_taken = ($signed(prf_rdata1) <  $signed(prf_rdata2));
         3'b101:  cond_taken = ($signed(prf_rdata1) >= $signed(prf_rdata2));
         3'b110:  cond_taken = (prf_rdata1 <  prf_rdata2);
         3'b111:  cond_taken = (prf_rdata1 >= prf_rdata2);
         default: legal      = 1'b0;
      endcase
      res_taken = e1_q.jump | cond_taken;
      pc4       = e1_q.pc + XLEN'(4);
      sum_reg   = prf_rdata1 + e1_q.imm;
      target    = (e1_q.jump && e1_q.jalr) ? {sum_reg[XLEN-1:1], 1'b0}
                                           : e1_q.pc + e1_q.imm;
      // JALR has no predicted target to compare against, so it always redirects
      if (e1_q.jump)
         mispredict = e1_q.jalr | ~e1_q.hit | ~e1_q.taken;
      else
         mispredict = legal & ((res_taken != e1_q.taken) | (res_taken & ~e1_q.hit));
      link = e1_q.jump && (e1_q.phy != '0);
   end

   always_comb begin
      e1_d          = '0;
      e2_d          = '0;
      br_cnt_d      = br_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      // A mispredict pulse squashes the younger E1 entry and the concurrent issue
      if (!exception_sig && !mret_sig && !e2_q.pr) begin
         if (in_branch || in_jump) begin
            e1_d.v        = 1'b1;
            e1_d.jump     = in_jump;
            e1_d.jalr     = in_jalr;
            e1_d.hit      = in_hit;
            e1_d.taken    = in_taken;
            e1_d.phy      = in_phy;
            e1_d.inst_num = in_inst_num;
            e1_d.funct3   = in_funct3;
            e1_d.imm      = in_imm;
            e1_d.pc       = in_pc;
            e1_d.op1      = in_op1_phy;
            e1_d.op2      = in_op2_phy;
         end
         if (e1_q.v) begin
            e2_d.pr        = mispredict;
            e2_d.redirect  = res_taken ? target : pc4;
            e2_d.btb_v     = 1'b1;
            e2_d.btb_pc    = e1_q.pc;
            e2_d.btb_tgt   = target;
            e2_d.btb_taken = res_taken;
            e2_d.done      = link;
            e2_d.phy       = link ? e1_q.phy : '0;
            e2_d.wdata     = link ? pc4 : '0;
            e2_d.inst_num  = e1_q.inst_num;
            br_cnt_d       = br_cnt_q + CNT_W'(1);
            if (mispredict)
               mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e1_q          <= '0;
         e2_q          <= '0;
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         e1_q          <= e1_d;
         e2_q          <= e2_d;
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign prf_raddr1     = e1_q.op1;
   assign prf_raddr2     = e1_q.op2;
   assign br_done        = e2_q.done;
   assign br_phy         = e2_q.phy;
   assign br_wdata       = e2_q.wdata;
   assign br_inst_num    = e2_q.inst_num;
   assign predict_result = e2_q.pr;
   assign redirect_pc    = e2_q.redirect;
   assign btb_upd_valid  = e2_q.btb_v;
   assign btb_upd_pc     = e2_q.btb_pc;
   assign btb_upd_target = e2_q.btb_tgt;
   assign btb_upd_taken  = e2_q.btb_taken;
   assign br_cnt         = br_cnt_q;
   assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: directed scenarios plus random issue
// traffic, compared each cycle against a behavioural model of the resolve rules.
module tb_br_resolve_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1, exception_sig = 1'b0, mret_sig = 1'b0;
   logic        in_branch = 0, in_jump = 0, in_jalr = 0, in_hit = 0, in_taken = 0;
   logic [7:0]  in_phy = '0, in_op1_phy = '0, in_op2_phy = '0;
   logic [31:0] in_inst_num = '0, in_imm = '0, in_pc = '0;
   logic [2:0]  in_funct3 = '0;
   logic [7:0]  prf_raddr1, prf_raddr2;
   logic [31:0] prf_rdata1, prf_rdata2;
   logic        br_done, predict_result, btb_upd_valid, btb_upd_taken;
   logic [7:0]  br_phy;
   logic [31:0] br_wdata, br_inst_num, redirect_pc, btb_upd_pc, btb_upd_target;
   logic [31:0] br_cnt, mispred_cnt;

   logic [31:0] rf [256];
   assign prf_rdata1 = rf[prf_raddr1];
   assign prf_rdata2 = rf[prf_raddr2];

   br_resolve_unit #(.XLEN(32), .PHY_W(8), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .exception_sig(exception_sig), .mret_sig(mret_sig),
      .in_branch(in_branch), .in_jump(in_jump), .in_jalr(in_jalr), .in_hit(in_hit),
      .in_taken(in_taken), .in_phy(in_phy), .in_inst_num(in_inst_num),
      .in_funct3(in_funct3), .in_imm(in_imm), .in_pc(in_pc),
      .in_op1_phy(in_op1_phy), .in_op2_phy(in_op2_phy),
      .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
      .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
      .br_done(br_done), .br_phy(br_phy), .br_wdata(br_wdata), .br_inst_num(br_inst_num),
      .predict_result(predict_result), .redirect_pc(redirect_pc),
      .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
      .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit br, jmp, jalr, hit, tk;
      bit [7:0] phy, op1, op2;
      bit [31:0] num, imm, pc;
      bit [2:0] f3;
   } iss_t;

   typedef struct {
      bit pr, bv, btk, done;
      bit [7:0] phy;
      bit [31:0] redirect, bpc, btgt, wdata, num;
   } out_t;

   int unsigned total = 0, bad = 0;
   iss_t  m_e1;
   bit    m_e1_v = 0;
   out_t  m_out = '{default: 0};
   bit [31:0] m_br = 0, m_mis = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural meaning of one branch/jump, straight from the ISA rules
   function automatic out_t resolve(input iss_t s);
      out_t o = '{default: 0};
      bit [31:0] a = rf[s.op1], b = rf[s.op2];
      bit tk, legal = 1, mis;
      bit [31:0] tgt;
      if (s.jmp) begin
         tk  = 1;
         tgt = s.jalr ? ((a + s.imm) & 32'hFFFF_FFFE) : s.pc + s.imm;
         mis = s.jalr || !s.hit || !s.tk;
      end else begin
         tgt = s.pc + s.imm;
         case (s.f3)
            0: tk = (a == b);
            1: tk = (a != b);
            4: tk = (int'(a) <  int'(b));
            5: tk = (int'(a) >= int'(b));
            6: tk = (a <  b);
            7: tk = (a >= b);
            default: begin tk = 0; legal = 0; end
         endcase
         mis = legal && ((tk != s.tk) || (tk && !s.hit));
      end
      o.pr = mis; o.bv = 1; o.btk = tk; o.btgt = tgt; o.bpc = s.pc; o.num = s.num;
      o.redirect = tk ? tgt : s.pc + 4;
      o.done = s.jmp && (s.phy != 0);
      o.phy  = o.done ? s.phy : 8'h0;
      o.wdata = o.done ? s.pc + 4 : 32'h0;
      return o;
   endfunction

   task automatic model_step();
      iss_t cur;
      out_t nxt = '{default: 0};
      bit prev_mis = m_out.pr;
      cur.br = in_branch; cur.jmp = in_jump; cur.jalr = in_jalr; cur.hit = in_hit;
      cur.tk = in_taken; cur.phy = in_phy; cur.op1 = in_op1_phy; cur.op2 = in_op2_phy;
      cur.num = in_inst_num; cur.imm = in_imm; cur.pc = in_pc; cur.f3 = in_funct3;
      if (reset) begin
         m_e1_v = 0; m_br = 0; m_mis = 0;
      end else if (exception_sig || mret_sig) begin
         m_e1_v = 0;
      end else begin
         if (m_e1_v && !prev_mis) begin
            nxt = resolve(m_e1);
            m_br++;
            if (nxt.pr) m_mis++;
         end
         m_e1_v = !prev_mis && (cur.br || cur.jmp);
         m_e1   = cur;
      end
      m_out = nxt;
   endtask

   task automatic check_all();
      chk("predict_result", predict_result, m_out.pr);
      chk("redirect_pc", redirect_pc, m_out.redirect);
      chk("btb_upd_valid", btb_upd_valid, m_out.bv);
      chk("btb_upd_pc", btb_upd_pc, m_out.bpc);
      chk("btb_upd_target", btb_upd_target, m_out.btgt);
      chk("btb_upd_taken", btb_upd_taken, m_out.btk);
      chk("br_done", br_done, m_out.done);
      chk("br_phy", br_phy, m_out.phy);
      chk("br_wdata", br_wdata, m_out.wdata);
      chk("br_inst_num", br_inst_num, m_out.num);
      chk("br_cnt", br_cnt, m_br);
      chk("mispred_cnt", mispred_cnt, m_mis);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic set_issue(input bit br, jmp, jalr, hit, tk, input bit [7:0] phy,
                            input bit [31:0] num, input bit [2:0] f3,
                            input bit [31:0] imm, pc, input bit [7:0] op1, op2);
      in_branch = br; in_jump = jmp; in_jalr = jalr; in_hit = hit; in_taken = tk;
      in_phy = phy; in_inst_num = num; in_funct3 = f3; in_imm = imm; in_pc = pc;
      in_op1_phy = op1; in_op2_phy = op2;
   endtask

   task automatic clr_issue();
      set_issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   bit [31:0] saved_br, saved_mis;

   initial begin
      for (int i = 0; i < 256; i++) rf[i] = $urandom;
      rf[1] = 32'd5; rf[2] = 32'd5; rf[3] = 32'hFFFF_FFFF; rf[4] = 32'd1; rf[5] = 32'h1003;

      tick(); tick();
      chk("reset_br_cnt", br_cnt, 32'd0);
      chk("reset_pr", predict_result, 1'b0);
      reset = 0;
      tick();

      // BEQ, equal operands, correctly predicted taken
      set_issue(1, 0, 0, 1, 1, 8'h11, 32'd1, 3'b000, 32'h20, 32'h100, 8'd1, 8'd2);
      tick(); clr_issue(); tick();
      chk("beq_taken", btb_upd_taken, 1'b1);
      chk("beq_target", btb_upd_target, 32'h120);
      chk("beq_pr", predict_result, 1'b0);
      chk("beq_cnt", br_cnt, 32'd1);
      tick();

      // BLT signed: -1 < 1 taken but predicted not-taken
      set_issue(1, 0, 0, 1, 0, 8'h0, 32'd2, 3'b100, 32'h40, 32'h300, 8'd3, 8'd4);
      tick(); clr_issue(); tick();
      chk("blt_pr", predict_result, 1'b1);
      chk("blt_redirect", redirect_pc, 32'h340);
      chk("blt_mis_cnt", mispred_cnt, 32'd1);
      tick();

      // BLTU same operands: not taken, predicted not-taken
      set_issue(1, 0, 0, 1, 0, 8'h0, 32'd3, 3'b110, 32'h40, 32'h300, 8'd3, 8'd4);
      tick(); clr_issue(); tick();
      chk("bltu_taken", btb_upd_taken, 1'b0);
      chk("bltu_pr", predict_result, 1'b0);
      chk("bltu_redirect", redirect_pc, 32'h304);
      tick();

      // JALR with link
      set_issue(0, 1, 1, 1, 1, 8'h2A, 32'd4, 3'b000, 32'd4, 32'h200, 8'd5, 8'd0);
      tick(); clr_issue(); tick();
      chk("jalr_done", br_done, 1'b1);
      chk("jalr_phy", br_phy, 8'h2A);
      chk("jalr_wdata", br_wdata, 32'h204);
      chk("jalr_redirect", redirect_pc, 32'h1006);
      chk("jalr_pr", predict_result, 1'b1);
      tick();

      // Back-to-back: mispredicting JALR then BEQ, which must be squashed
      saved_br = br_cnt;
      set_issue(0, 1, 1, 1, 1, 8'h07, 32'd5, 3'b000, 32'd4, 32'h200, 8'd5, 8'd0);
      tick();
      set_issue(1, 0, 0, 1, 1, 8'h0, 32'd6, 3'b000, 32'h20, 32'h100, 8'd1, 8'd2);
      tick();
      chk("b2b_a_pr", predict_result, 1'b1);
      clr_issue(); tick();
      chk("b2b_b_valid", btb_upd_valid, 1'b0);
      chk("b2b_b_pr", predict_result, 1'b0);
      chk("b2b_cnt", br_cnt, saved_br + 1);
      tick();

      // Exception while E1 and E2 both hold instructions
      set_issue(1, 0, 0, 1, 1, 8'h0, 32'd7, 3'b000, 32'h20, 32'h100, 8'd1, 8'd2);
      tick();
      set_issue(1, 0, 0, 1, 1, 8'h0, 32'd8, 3'b000, 32'h20, 32'h180, 8'd1, 8'd2);
      tick();
      saved_br = br_cnt; saved_mis = mispred_cnt;
      chk("exc_pre_valid", btb_upd_valid, 1'b1);
      set_issue(0, 1, 0, 0, 0, 8'h09, 32'd9, 3'b000, 32'h8, 32'h400, 8'd1, 8'd2);
      exception_sig = 1;
      tick();
      exception_sig = 0; clr_issue();
      chk("exc_valid", btb_upd_valid, 1'b0);
      chk("exc_cnt", br_cnt, saved_br);
      tick();
      chk("exc_drop_b", btb_upd_valid, 1'b0);
      chk("exc_mis_cnt", mispred_cnt, saved_mis);

      // BNE with PC wrap-around, taken but BTB miss
      set_issue(1, 0, 0, 0, 1, 8'h0, 32'd10, 3'b001, 32'd8, 32'hFFFF_FFFC, 8'd1, 8'd3);
      tick(); clr_issue(); tick();
      chk("bne_target", btb_upd_target, 32'h4);
      chk("bne_pr", predict_result, 1'b1);
      tick();

      // Illegal funct3: not taken, no mispredict, still counted
      saved_br = br_cnt;
      set_issue(1, 0, 0, 1, 1, 8'h0, 32'd11, 3'b010, 32'h10, 32'h500, 8'd1, 8'd2);
      tick(); clr_issue(); tick();
      chk("ill_taken", btb_upd_taken, 1'b0);
      chk("ill_pr", predict_result, 1'b0);
      chk("ill_cnt", br_cnt, saved_br + 1);
      tick();

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            int unsigned kind = $urandom_range(0, 3);
            bit [7:0] o1 = 8'($urandom);
            bit [7:0] o2 = $urandom_range(0, 1) ? o1 : 8'($urandom);
            bit [7:0] ph = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
            set_issue(kind < 2, kind >= 2, kind == 3, 1'($urandom), 1'($urandom), ph,
                      $urandom, 3'($urandom), $urandom, $urandom, o1, o2);
         end else
            clr_issue();
         exception_sig = ($urandom_range(0, 29) == 0);
         mret_sig      = ($urandom_range(0, 29) == 0);
         reset         = ($urandom_range(0, 149) == 0);
         tick();
      end
      clr_issue(); exception_sig = 0; mret_sig = 0; reset = 0;
      tick(); tick();

      reset = 1;
      tick();
      chk("final_reset_br_cnt", br_cnt, 32'd0);
      chk("final_reset_mis_cnt", mispred_cnt, 32'd0);
      reset = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
